mac_rx_pkt_fifo: RTL

MAC_RX_PKT_FIFO -- requirements
Module: mac_rx_pkt_fifo

---
 rtl/mac_rx_pkt_fifo_if.sv | 49 ++++
 rtl/mac_rx_pkt_fifo.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mac_rx_pkt_fifo_if.sv
// ============================================================================
// Module      : mac_rx_pkt_fifo_if
// Description : Bundles the MAC receive beat stream, the committed-frame
//               read port and the status counters of mac_rx_pkt_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mac_rx_pkt_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) ();

  // MAC receive side
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_last;
  logic              rx_err;
  logic              rx_ready;

  // Committed-frame read side
  logic              fifo_valid;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_last;
  logic              fifo_ready;
  logic              fifo_fire;

  // Status
  logic [ADDR_W:0]   level;
  logic [ADDR_W:0]   frame_cnt;
  logic [15:0]       drop_cnt;

  // Environment side: drives beats and the downstream accept
  modport master (
    output rx_valid, rx_data, rx_last, rx_err, fifo_ready,
    input  rx_ready, fifo_valid, fifo_data, fifo_last, fifo_fire,
           level, frame_cnt, drop_cnt
  );

  // FIFO side
  modport slave (
    input  rx_valid, rx_data, rx_last, rx_err, fifo_ready,
    output rx_ready, fifo_valid, fifo_data, fifo_last, fifo_fire,
           level, frame_cnt, drop_cnt
  );

endinterface

`default_nettype wire

// File: rtl/mac_rx_pkt_fifo.sv
// ============================================================================
// Module      : mac_rx_pkt_fifo
// Description : Store-and-forward receive packet FIFO. Beats are written
//               tentatively and become readable only once the frame ends
//               without error; bad or oversized frames are rolled back and
//               counted as drops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_rx_pkt_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  mac_rx_pkt_fifo_if.slave bus
);

  localparam int PTR_W = ADDR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  localparam logic [PTR_W-1:0] c_depth    = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
  localparam logic [15:0]      c_drop_max = 16'hFFFF;

  // Each entry stores {last, data}
  logic [DATA_W:0]    r_mem [DEPTH];

  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_wr_commit;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_frame_cnt;
  logic [15:0]        r_drop_cnt;
  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;

  logic               w_beat;
  logic               w_full;
  logic               w_wr_en;
  logic               w_commit;
  logic               w_drop;
  logic               w_valid;
  logic               w_fire;
  logic               w_rd_last;
  logic [DATA_W-1:0]  w_rd_data;

  // Beats are only taken outside reset, matching rx_ready
  assign w_beat = bus.rx_valid && !rst;
  // Space is judged from registered pointers only, so a same-cycle read frees nothing
  assign w_full = ((r_wr_ptr - r_rd_ptr) == c_depth);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode: oversized frames fall into DROP until their last beat
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_RECV: begin
        if (w_beat) begin
          if (w_full)           w_state_nxt = bus.rx_last ? S_IDLE : S_DROP;
          else if (bus.rx_last) w_state_nxt = S_IDLE;
          else                  w_state_nxt = S_RECV;
        end
      end
      S_DROP: begin
        if (w_beat && bus.rx_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: write, commit and drop strobes for the datapath
  always_comb begin
    w_wr_en  = 1'b0;
    w_commit = 1'b0;
    w_drop   = 1'b0;
    if (((r_state == S_IDLE) || (r_state == S_RECV)) && w_beat) begin
      if (w_full || (bus.rx_last && bus.rx_err)) begin
        w_drop = 1'b1;
      end else begin
        w_wr_en  = 1'b1;
        w_commit = bus.rx_last;
      end
    end
  end

  // Pointer update: a drop rewinds the tentative pointer to the last commit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_rd_ptr    <= '0;
    end else begin
      if (w_drop)       r_wr_ptr <= r_wr_commit;
      else if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_commit)     r_wr_commit <= r_wr_ptr + c_ptr_one;
      if (w_fire)       r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  // Frame and drop counters; a commit and a last-beat read cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      case ({w_commit, w_fire && w_rd_last})
        2'b10:   r_frame_cnt <= r_frame_cnt + c_ptr_one;
        2'b01:   r_frame_cnt <= r_frame_cnt - c_ptr_one;
        default: r_frame_cnt <= r_frame_cnt;
      endcase
      if (w_drop && (r_drop_cnt != c_drop_max)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // Beat storage; contents need no reset since nothing reads an empty FIFO
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[ADDR_W-1:0]] <= {bus.rx_last, bus.rx_data};
  end

  assign {w_rd_last, w_rd_data} = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign w_valid = !rst && (r_wr_commit != r_rd_ptr);
  assign w_fire  = w_valid && bus.fifo_ready;

  assign bus.rx_ready   = !rst;
  assign bus.fifo_valid = w_valid;
  assign bus.fifo_data  = w_rd_data;
  assign bus.fifo_last  = w_rd_last;
  assign bus.fifo_fire  = w_fire;
  assign bus.level      = rst ? '0 : (r_wr_commit - r_rd_ptr);
  assign bus.frame_cnt  = r_frame_cnt;
  assign bus.drop_cnt   = r_drop_cnt;

endmodule

`default_nettype wire
